// File: rtl/pipeline_controller.sv
// Hazard/stall/flush controller for a 5-stage pipeline: combinational stage enables from state and inputs.
// Latency: outputs follow inputs in the same cycle; a memory stall freezes every stage and resumes the pre-stall state.
module pipeline_controller #(
    parameter int REGISTER_INDEX_WIDTH = 5,
    parameter int FLUSH_CYCLES         = 2,
    parameter int COUNTER_WIDTH        = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [REGISTER_INDEX_WIDTH-1:0] id_src1_addr,
    input  logic [REGISTER_INDEX_WIDTH-1:0] id_src2_addr,
    input  logic                            id_uses_src2,
    input  logic [REGISTER_INDEX_WIDTH-1:0] ex_dst_addr,
    input  logic                            ex_mem_read,
    input  logic                            ex_branch_taken,
    input  logic                            mem_access,
    input  logic                            dcache_ready,
    input  logic                            icache_ready,
    output logic                            pc_write_en,
    output logic                            if_id_write_en,
    output logic                            if_id_flush,
    output logic                            id_ex_write_en,
    output logic                            id_ex_bubble,
    output logic                            ex_mem_write_en,
    output logic [1:0]                      state_out,
    output logic [COUNTER_WIDTH-1:0]        stall_cycles_out,
    output logic [COUNTER_WIDTH-1:0]        flush_count_out
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    state_t                   state_q, state_d;
    state_t                   saved_q, saved_d;
    state_t                   eff_state;
    logic [3:0]               remain_q, remain_d;
    logic [COUNTER_WIDTH-1:0] stall_q, stall_d;
    logic [COUNTER_WIDTH-1:0] flush_q, flush_d;
    logic                     load_use;
    logic                     mem_stall;

    assign load_use = ex_mem_read && (ex_dst_addr != '0) &&
                      ((ex_dst_addr == id_src1_addr) ||
                       (id_uses_src2 && (ex_dst_addr == id_src2_addr)));
    assign mem_stall = mem_access && !dcache_ready;

    // MEM_WAIT is transparent once the stall clears: the saved state governs that very cycle.
    assign eff_state = (state_q == MEM_WAIT) ? saved_q : state_q;

    assign stall_cycles_out = stall_q;
    assign flush_count_out  = flush_q;

    always_comb begin
        pc_write_en     = 1'b0;
        if_id_write_en  = 1'b0;
        if_id_flush     = 1'b0;
        id_ex_write_en  = 1'b0;
        id_ex_bubble    = 1'b0;
        ex_mem_write_en = 1'b0;
        state_out       = RUN;
        state_d         = state_q;
        saved_d         = saved_q;
        remain_d        = remain_q;
        stall_d         = stall_q;
        flush_d         = flush_q;

        if (reset) begin
            if (mem_stall) begin
                state_out = MEM_WAIT;
                state_d   = MEM_WAIT;
                saved_d   = eff_state;
                stall_d   = (&stall_q) ? stall_q : stall_q + 1'b1;
            end else if (eff_state == FLUSH) begin
                pc_write_en     = 1'b1;
                if_id_write_en  = 1'b1;
                if_id_flush     = 1'b1;
                id_ex_write_en  = 1'b1;
                id_ex_bubble    = 1'b1;
                ex_mem_write_en = 1'b1;
                state_out       = FLUSH;
                remain_d        = remain_q - 4'd1;
                state_d         = (remain_q == 4'd1) ? RUN : FLUSH;
                saved_d         = RUN;
            end else begin
                pc_write_en     = 1'b1;
                if_id_write_en  = 1'b1;
                id_ex_write_en  = 1'b1;
                ex_mem_write_en = 1'b1;
                state_out       = RUN;
                state_d         = RUN;
                saved_d         = RUN;
                if (ex_branch_taken) begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    flush_d      = (&flush_q) ? flush_q : flush_q + 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d  = FLUSH;
                        remain_d = FLUSH_INIT;
                    end
                end else if (load_use) begin
                    pc_write_en    = 1'b0;
                    if_id_write_en = 1'b0;
                    id_ex_bubble   = 1'b1;
                end else if (!icache_ready) begin
                    pc_write_en = 1'b0;
                    if_id_flush = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= RUN;
            saved_q  <= RUN;
            remain_q <= 4'd0;
            stall_q  <= '0;
            flush_q  <= '0;
        end else begin
            state_q  <= state_d;
            saved_q  <= saved_d;
            remain_q <= remain_d;
            stall_q  <= stall_d;
            flush_q  <= flush_d;
        end
    end

endmodule

// File: tb/tb_pipeline_controller.sv
// Bench for pipeline_controller: directed scenarios with literal expectations, then random traffic,
// all outputs compared every cycle against a flush-countdown model of the controller.
module tb_pipeline_controller;

    localparam int FC = 2;
    localparam int RW = 5;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [RW-1:0] id_src1_addr, id_src2_addr, ex_dst_addr;
    logic          id_uses_src2, ex_mem_read, ex_branch_taken;
    logic          mem_access, dcache_ready, icache_ready;
    logic          pc_write_en, if_id_write_en, if_id_flush;
    logic          id_ex_write_en, id_ex_bubble, ex_mem_write_en;
    logic [1:0]    state_out;
    logic [CW-1:0] stall_cycles_out, flush_count_out;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: flush_left counts flush cycles still owed; a stall simply postpones them.
    int m_flush_left = 0;
    int m_stall      = 0;
    int m_flushes    = 0;

    pipeline_controller #(
        .REGISTER_INDEX_WIDTH(RW),
        .FLUSH_CYCLES(FC),
        .COUNTER_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .id_src1_addr(id_src1_addr), .id_src2_addr(id_src2_addr), .id_uses_src2(id_uses_src2),
        .ex_dst_addr(ex_dst_addr), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_access(mem_access), .dcache_ready(dcache_ready), .icache_ready(icache_ready),
        .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en), .if_id_flush(if_id_flush),
        .id_ex_write_en(id_ex_write_en), .id_ex_bubble(id_ex_bubble), .ex_mem_write_en(ex_mem_write_en),
        .state_out(state_out), .stall_cycles_out(stall_cycles_out), .flush_count_out(flush_count_out)
    );

    always #5 clk = ~clk;

    function automatic logic model_hazard();
        int d, s1, s2;
        d  = int'(ex_dst_addr);
        s1 = int'(id_src1_addr);
        s2 = int'(id_src2_addr);
        return (ex_mem_read == 1'b1) && (d != 0) && (d == s1 || (id_uses_src2 == 1'b1 && d == s2));
    endfunction

    // Packed as {pc, if_id_we, if_id_flush, id_ex_we, bubble, ex_mem_we, state[1:0], stall[15:0], flushes[15:0]}.
    function automatic logic [40:0] model_out();
        logic [5:0] ctl;
        int         st;
        ctl = 6'b000000;
        st  = 0;
        if (reset == 1'b1) begin
            if (mem_access && !dcache_ready) begin
                ctl = 6'b000000; st = 2;
            end else if (m_flush_left > 0) begin
                ctl = 6'b111111; st = 1;
            end else if (ex_branch_taken) begin
                ctl = 6'b111111; st = 0;
            end else if (model_hazard()) begin
                ctl = 6'b000111; st = 0;
            end else if (!icache_ready) begin
                ctl = 6'b011101; st = 0;
            end else begin
                ctl = 6'b110101; st = 0;
            end
        end
        return {ctl, 2'(st), 16'(m_stall), 16'(m_flushes)};
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_flush_left <= 0;
            m_stall      <= 0;
            m_flushes    <= 0;
        end else if (mem_access && !dcache_ready) begin
            m_stall <= (m_stall < 65535) ? m_stall + 1 : 65535;
        end else if (m_flush_left > 0) begin
            m_flush_left <= m_flush_left - 1;
        end else if (ex_branch_taken) begin
            m_flushes    <= (m_flushes < 65535) ? m_flushes + 1 : 65535;
            m_flush_left <= FC - 1;
        end
    end

    always @(negedge clk) begin
        logic [40:0] act, exp_v;
        act   = {pc_write_en, if_id_write_en, if_id_flush, id_ex_write_en, id_ex_bubble,
                 ex_mem_write_en, state_out, stall_cycles_out, flush_count_out};
        exp_v = model_out();
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL model t=%0t outputs got %h expected %h", $time, act, exp_v);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s t=%0t got %0h expected %0h", name, $time, act, exp_v);
        end
    endtask

    task automatic idle();
        id_src1_addr = 5'd1; id_src2_addr = 5'd2; ex_dst_addr = 5'd3; id_uses_src2 = 1'b0;
        ex_mem_read = 1'b0; ex_branch_taken = 1'b0; mem_access = 1'b0;
        dcache_ready = 1'b1; icache_ready = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_en(input string name, input logic [5:0] exp_v);
        chk(name, {26'd0, pc_write_en, if_id_write_en, if_id_flush, id_ex_write_en, id_ex_bubble,
                   ex_mem_write_en}, {26'd0, exp_v});
    endtask

    initial begin
        reset = 1'b0;
        idle();
        #3;
        chk_en("reset_enables", 6'b000000);
        chk("reset_state", 32'(state_out), 32'd0);
        chk("reset_stall_cnt", 32'(stall_cycles_out), 32'd0);
        chk("reset_flush_cnt", 32'(flush_count_out), 32'd0);
        tick(); tick();
        reset = 1'b1;
        #2;
        chk_en("run_normal", 6'b110101);

        // Load-use on src2, then the load moves on.
        ex_mem_read = 1'b1; ex_dst_addr = 5'd5; id_src2_addr = 5'd5; id_uses_src2 = 1'b1;
        #2;
        chk_en("load_use_src2", 6'b000111);
        tick();
        ex_mem_read = 1'b0;
        #2;
        chk_en("load_use_after", 6'b110101);
        tick();
        ex_mem_read = 1'b1; ex_dst_addr = 5'd0; id_src2_addr = 5'd0;
        #2;
        chk("no_bubble_r0", 32'(id_ex_bubble), 32'd0);
        tick();
        ex_dst_addr = 5'd5; id_src2_addr = 5'd5; id_uses_src2 = 1'b0;
        #2;
        chk("no_bubble_unused_src2", 32'(id_ex_bubble), 32'd0);
        tick();
        idle();

        // Branch with a two-cycle flush.
        ex_branch_taken = 1'b1;
        #2;
        chk("br_state0", 32'(state_out), 32'd0);
        chk_en("br_cycle0", 6'b111111);
        tick();
        ex_branch_taken = 1'b0;
        #2;
        chk("br_state1", 32'(state_out), 32'd1);
        chk_en("br_cycle1", 6'b111111);
        tick();
        #2;
        chk("br_state2", 32'(state_out), 32'd0);
        chk("br_flush_off", 32'(if_id_flush), 32'd0);
        chk("br_flush_cnt", 32'(flush_count_out), 32'd1);

        // Branch, then a three-cycle memory stall in the middle of the flush.
        ex_branch_taken = 1'b1;
        tick();
        ex_branch_taken = 1'b0; mem_access = 1'b1; dcache_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk_en("stall_enables", 6'b000000);
            chk("stall_state", 32'(state_out), 32'd2);
            tick();
        end
        mem_access = 1'b0; dcache_ready = 1'b1;
        #2;
        chk("stall_cnt3", 32'(stall_cycles_out), 32'd3);
        chk("resume_flush_state", 32'(state_out), 32'd1);
        chk("resume_flush", 32'(if_id_flush), 32'd1);
        tick();
        #2;
        chk("resume_run_state", 32'(state_out), 32'd0);
        chk("resume_run_flush", 32'(if_id_flush), 32'd0);

        // Branch and load-use together: flush wins.
        ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_dst_addr = 5'd7; id_src1_addr = 5'd7;
        #2;
        chk_en("br_over_lu", 6'b111111);
        tick();
        idle();
        tick();
        #2;
        chk("flush_cnt3", 32'(flush_count_out), 32'd3);

        // Drive the stall counter to saturation, then stall once more.
        mem_access = 1'b1; dcache_ready = 1'b0;
        repeat (65532) tick();
        #2;
        chk("stall_sat", 32'(stall_cycles_out), 32'hFFFF);
        tick();
        #2;
        chk("stall_sat_hold", 32'(stall_cycles_out), 32'hFFFF);
        chk("mem_wait_state", 32'(state_out), 32'd2);

        // Reset in MEM_WAIT.
        reset = 1'b0;
        #1;
        chk_en("rst_mid_enables", 6'b000000);
        chk("rst_mid_stall_cnt", 32'(stall_cycles_out), 32'd0);
        chk("rst_mid_flush_cnt", 32'(flush_count_out), 32'd0);
        tick();
        reset = 1'b1;
        idle();
        #2;
        chk("rst_release_state", 32'(state_out), 32'd0);
        chk_en("rst_release_en", 6'b110101);
        tick();

        // Randomized traffic, checked by the per-cycle model comparison.
        for (int i = 0; i < 2000; i++) begin
            id_src1_addr    = 5'($urandom_range(0, 3));
            id_src2_addr    = 5'($urandom_range(0, 3));
            ex_dst_addr     = 5'($urandom_range(0, 3));
            id_uses_src2    = 1'($urandom_range(0, 1));
            ex_mem_read     = ($urandom_range(0, 2) == 0);
            ex_branch_taken = ($urandom_range(0, 5) == 0);
            mem_access      = ($urandom_range(0, 3) == 0);
            dcache_ready    = 1'($urandom_range(0, 1));
            icache_ready    = ($urandom_range(0, 4) != 0);
            tick();
        end
        idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
